// File: rtl/bcd_ex3_pkg.sv
// rtl/bcd_ex3_pkg.sv - shared types and constants for the BCD to Excess-3 sequencer
package bcd_ex3_pkg;

    localparam int          DIGIT_W    = 4;
    localparam logic [3:0]  EX3_OFFSET = 4'd3;
    localparam logic [3:0]  BCD_MAX    = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bcd_ex3_digit.sv
// rtl/bcd_ex3_digit.sv - combinational single-digit BCD to Excess-3 converter with invalid flag
module bcd_ex3_digit
    import bcd_ex3_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_bcd,
    output logic [DIGIT_W-1:0] o_ex3,
    output logic               o_invalid
);

    // Non-BCD codes still convert arithmetically and simply wrap at 16.
    assign o_ex3     = i_bcd + EX3_OFFSET;
    assign o_invalid = (i_bcd > BCD_MAX);

endmodule

// File: rtl/bcd_ex3_seq.sv
// rtl/bcd_ex3_seq.sv - serial BCD to Excess-3 word converter, one digit per clock; optional tap ports under BCD_EX3_SEQ_TAP_EN
module bcd_ex3_seq
    import bcd_ex3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_ex3,
    output logic                  out_err,
    output logic                  busy
`ifdef BCD_EX3_SEQ_TAP_EN
    ,
    output logic                  tap_valid,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] tap_idx,
    output logic [3:0]            tap_ex3
`endif
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_sh;
    logic [W-1:0]    r_res;
    logic [W-1:0]    r_out;
    logic [W-1:0]    w_res_next;
    logic            r_err;
    logic            r_out_err;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      w_ex3;
    logic            w_inv;
    logic            w_last;

    bcd_ex3_digit u_digit (
        .i_bcd     (r_sh[DIGIT_W-1:0]),
        .o_ex3     (w_ex3),
        .o_invalid (w_inv)
    );

    assign w_last = (r_cnt == CW'(DIGITS - 1));

    // Converted digits enter at the top so digit 0 lands at the bottom after DIGITS shifts.
    generate
        if (DIGITS == 1) begin : g_res_one
            assign w_res_next = w_ex3;
        end else begin : g_res_multi
            assign w_res_next = {w_ex3, r_res[W-1:DIGIT_W]};
        end
    endgenerate

    // State register; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !rst;
                if (in_valid) w_next = CONV;
            end
            CONV: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, shift one digit per CONV cycle, publish result on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh      <= '0;
            r_res     <= '0;
            r_out     <= '0;
            r_err     <= 1'b0;
            r_out_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sh  <= in_bcd;
                        r_err <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                CONV: begin
                    r_sh  <= r_sh >> DIGIT_W;
                    r_res <= w_res_next;
                    r_err <= r_err | w_inv;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out     <= w_res_next;
                        r_out_err <= r_err | w_inv;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_ex3 = r_out;
    assign out_err = r_out_err;

`ifdef BCD_EX3_SEQ_TAP_EN
    // Debug tap exposes the converter each CONV cycle and is zeroed otherwise.
    assign tap_valid = (r_state == CONV);
    assign tap_idx   = tap_valid ? r_cnt : '0;
    assign tap_ex3   = tap_valid ? w_ex3 : 4'd0;
`endif

endmodule

// File: tb/tb_bcd_ex3_seq.sv
// tb/tb_bcd_ex3_seq.sv - directed self-checking bench for bcd_ex3_seq
module tb_bcd_ex3_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ex3;
    logic        out_err;
    logic        busy;
`ifdef BCD_EX3_SEQ_TAP_EN
    logic        tap_valid;
    logic [1:0]  tap_idx;
    logic [3:0]  tap_ex3;
`endif

    int n_pass  = 0;
    int n_total = 0;

    bcd_ex3_seq #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ex3   (out_ex3),
        .out_err   (out_err),
        .busy      (busy)
`ifdef BCD_EX3_SEQ_TAP_EN
        ,
        .tap_valid (tap_valid),
        .tap_idx   (tap_idx),
        .tap_ex3   (tap_ex3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Offer one word with out_ready=1, check latency, result, error and return to IDLE.
    task automatic run_word(input string tag, input logic [15:0] w,
                            input logic [15:0] exp_ex3, input logic exp_err);
        int k;
        int lat;
        in_bcd   = w;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_ex3"}, 32'(out_ex3), 32'(exp_ex3));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        tick();
        check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int bad;
        int k;
        logic [15:0] h_ex3;
        logic        h_err;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ex3",   32'(out_ex3),   32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready",  32'(in_ready),  32'd1);

        // Plain word.
        run_word("t1", 16'h1234, 16'h4567, 1'b0);

        // Back-to-back words with in_valid held high.
        in_bcd   = 16'h0909;
        in_valid = 1'b1;
        tick();
        in_bcd = 16'h0000;
        bad = 0;
        k   = 0;
        while (!out_valid && k < 20) begin
            if (in_ready) bad++;
            tick();
            k++;
        end
        if (in_ready) bad++;
        check("t2_ready_low", 32'(bad), 32'd0);
        check("t2_busy",      32'(busy), 32'd1);
        check("t2a_ex3",      32'(out_ex3), 32'h3C3C);
        check("t2a_err",      32'(out_err), 32'd0);
        tick();
        check("t2_idle_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("t2b_lat", 32'(k), 32'd4);
        check("t2b_ex3", 32'(out_ex3), 32'h3333);
        check("t2b_err", 32'(out_err), 32'd0);
        tick();

        // Invalid digit sets err, next word clears it.
        run_word("t3a", 16'h12A4, 16'h45D7, 1'b1);
        run_word("t3b", 16'h0001, 16'h3334, 1'b0);

        // Backpressure in DONE.
        out_ready = 1'b0;
        in_bcd    = 16'h5678;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("t4_lat", 32'(k), 32'd4);
        h_ex3 = out_ex3;
        h_err = out_err;
        check("t4_ex3", 32'(h_ex3), 32'h89AB);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_ex3 !== h_ex3 || out_err !== h_err || in_ready) bad++;
        end
        check("t4_stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        tick();
        check("t4_release", {29'd0, out_valid, in_ready, busy}, 32'b010);

        // Reset in the second CONV cycle.
        in_bcd   = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_rst_outs", {13'd0, out_valid, out_err, busy, out_ex3}, 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("t5_rel_ready", 32'(in_ready), 32'd1);
        run_word("t5", 16'h9999, 16'hCCCC, 1'b0);

`ifdef BCD_EX3_SEQ_TAP_EN
        // Per-digit tap.
        check("t6_tap_idle", {25'd0, tap_valid, tap_idx, tap_ex3}, 32'd0);
        in_bcd   = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t6_tap0", {25'd0, tap_valid, tap_idx, tap_ex3}, {25'd0, 1'b1, 2'd0, 4'd7});
        tick();
        check("t6_tap1", {25'd0, tap_valid, tap_idx, tap_ex3}, {25'd0, 1'b1, 2'd1, 4'd6});
        tick();
        check("t6_tap2", {25'd0, tap_valid, tap_idx, tap_ex3}, {25'd0, 1'b1, 2'd2, 4'd5});
        tick();
        check("t6_tap3", {25'd0, tap_valid, tap_idx, tap_ex3}, {25'd0, 1'b1, 2'd3, 4'd4});
        tick();
        check("t6_tap_done", 32'(tap_valid), 32'd0);
        check("t6_ex3", 32'(out_ex3), 32'h4567);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
